// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash READ responder.
// Defining FAST_READ_EN adds the 0x0B command and its DUMMY state.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CMD_BITS   = 5'd8;
    localparam logic [CNT_W-1:0] ADDR_BITS  = 5'd24;
    localparam logic [CNT_W-1:0] DUMMY_BITS = 5'd8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
`ifdef FAST_READ_EN
        , ST_DUMMY = 3'd5
`endif
    } state_e;

    function automatic logic is_last_bit(input logic [CNT_W-1:0] cnt,
                                         input logic [CNT_W-1:0] nbits);
        return cnt == nbits - 1'b1;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Oversamples SCK, CS_N and MOSI into the system clock domain and derives
// SCK edge strobes plus a chip-select falling strobe.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetq,
    input  logic sck_i,
    input  logic cs_n_i,
    input  logic mosi_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic cs_active_o,
    output logic cs_fall_o,
    output logic mosi_o
);

    logic [SYNC_STAGES-1:0] sck_q, cs_n_q, mosi_q;
    logic                   sck_prev_q, cs_act_prev_q;

    // CS_N resets to "selected" so a select held low through reset is not
    // mistaken for a fresh falling edge once reset is released.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            sck_q         <= '0;
            cs_n_q        <= '0;
            mosi_q        <= '0;
            sck_prev_q    <= 1'b0;
            cs_act_prev_q <= 1'b1;
        end else begin
            sck_q[0]  <= sck_i;
            cs_n_q[0] <= cs_n_i;
            mosi_q[0] <= mosi_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_q[i]  <= sck_q[i-1];
                cs_n_q[i] <= cs_n_q[i-1];
                mosi_q[i] <= mosi_q[i-1];
            end
            sck_prev_q    <= sck_q[SYNC_STAGES-1];
            cs_act_prev_q <= ~cs_n_q[SYNC_STAGES-1];
        end
    end

    assign sck_rise_o  =  sck_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall_o  = ~sck_q[SYNC_STAGES-1] &  sck_prev_q;
    assign cs_active_o = ~cs_n_q[SYNC_STAGES-1];
    assign cs_fall_o   =  cs_active_o & ~cs_act_prev_q;
    assign mosi_o      =  mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash READ (0x03) target streaming bytes from a memory port.
// Optional FAST_READ_EN macro enables 0x0B with 8 dummy clocks.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  resetq,
    input  logic                  SCK,
    input  logic                  CS_N,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_OE,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_strb,
    input  logic [7:0]            rd_data,
    output logic                  active,
    output logic                  unsupported
);

    logic sck_rise, sck_fall, cs_active, cs_fall, mosi_s;

    spi_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .resetq     (resetq),
        .sck_i      (SCK),
        .cs_n_i     (CS_N),
        .mosi_i     (MOSI),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .cs_active_o(cs_active),
        .cs_fall_o  (cs_fall),
        .mosi_o     (mosi_s)
    );

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [22:0]           sh_q, sh_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  strb_q, strb_d;
    logic                  cap_q, cap_d;
    logic [7:0]            buf_q, buf_d;
    logic [7:0]            out_q, out_d;
    logic [2:0]            obit_q, obit_d;
    logic                  miso_q, miso_d;
    logic                  unsup_q, unsup_d;
    logic                  drive;
    logic [23:0]           word_in;
    logic                  unused_hi;
`ifdef FAST_READ_EN
    logic                  fast_q, fast_d;
`endif

    // Upper address bits beyond ADDR_WIDTH are deliberately discarded.
    assign word_in   = {sh_q, mosi_s};
    assign unused_hi = ^word_in;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            strb_q  <= 1'b0;
            cap_q   <= 1'b0;
            buf_q   <= '0;
            out_q   <= '0;
            obit_q  <= '0;
            miso_q  <= 1'b0;
            unsup_q <= 1'b0;
`ifdef FAST_READ_EN
            fast_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            cap_q   <= cap_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            obit_q  <= obit_d;
            miso_q  <= miso_d;
            unsup_q <= unsup_d;
`ifdef FAST_READ_EN
            fast_q  <= fast_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        addr_d  = addr_q;
        strb_d  = 1'b0;
        cap_d   = strb_q;
        buf_d   = cap_q ? rd_data : buf_q;
        out_d   = out_q;
        obit_d  = obit_q;
        miso_d  = miso_q;
        unsup_d = 1'b0;
        drive   = 1'b0;
`ifdef FAST_READ_EN
        fast_d  = fast_q;
`endif
        // Deselect wins over any SCK edge seen in the same cycle.
        if (!cs_active) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            obit_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_CMD;
                        cnt_d   = '0;
`ifdef FAST_READ_EN
                        fast_d  = 1'b0;
`endif
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        sh_d  = word_in[22:0];
                        cnt_d = cnt_q + 1'b1;
                        if (is_last_bit(cnt_q, CMD_BITS)) begin
                            cnt_d = '0;
                            if (word_in[7:0] == CMD_READ) begin
                                state_d = ST_ADDR;
                            end
`ifdef FAST_READ_EN
                            else if (word_in[7:0] == CMD_FAST_READ) begin
                                state_d = ST_ADDR;
                                fast_d  = 1'b1;
                            end
`endif
                            else begin
                                state_d = ST_IGNORE;
                                unsup_d = 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        sh_d  = word_in[22:0];
                        cnt_d = cnt_q + 1'b1;
                        if (is_last_bit(cnt_q, ADDR_BITS)) begin
                            cnt_d  = '0;
                            addr_d = word_in[ADDR_WIDTH-1:0];
                            strb_d = 1'b1;
                            obit_d = '0;
`ifdef FAST_READ_EN
                            state_d = fast_q ? ST_DUMMY : ST_DATA;
`else
                            state_d = ST_DATA;
`endif
                        end
                    end
                end
`ifdef FAST_READ_EN
                ST_DUMMY: begin
                    if (sck_rise && cnt_q != DUMMY_BITS) cnt_d = cnt_q + 1'b1;
                    if (sck_fall && cnt_q == DUMMY_BITS) begin
                        state_d = ST_DATA;
                        drive   = 1'b1;
                    end
                end
`endif
                ST_DATA: drive = sck_fall;
                default: ;
            endcase

            // Starting a byte consumes the buffer and prefetches the next one.
            if (drive) begin
                if (obit_q == 3'd0) begin
                    miso_d = buf_q[7];
                    out_d  = {buf_q[6:0], 1'b0};
                    addr_d = addr_q + 1'b1;
                    strb_d = 1'b1;
                end else begin
                    miso_d = out_q[7];
                    out_d  = {out_q[6:0], 1'b0};
                end
                obit_d = obit_q + 3'd1;
            end
        end
    end

    assign MISO_OE     = (state_q == ST_DATA);
    assign MISO        = MISO_OE & miso_q;
    assign rd_addr     = addr_q;
    assign rd_strb     = strb_q;
    assign active      = cs_active & (state_q != ST_IDLE);
    assign unsupported = unsup_q;

endmodule
